// File: rtl/alu_board_ctrl_if.sv
// Board-side signal bundle for alu_board_ctrl: switch bank, raw buttons, ALU
// feedback in; operand/op registers, display data and status out.
interface alu_board_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic [WIDTH-1:0] sw;
  logic             btn_load_a;
  logic             btn_load_b;
  logic             btn_load_op;
  logic             btn_page;
  logic [WIDTH-1:0] alu_f;
  logic [3:0]       alu_nzcv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  alu_op;
  logic             cf_in;
  logic             vf_in;
  logic             shift_cout;
  logic [WIDTH-1:0] disp_data;
  logic [1:0]       page;
  logic [3:0]       nzcv_led;
  logic             result_valid;
  logic [2:0]       dbg_loaded;

  // There is no valid/ready handshake here: result_valid is a level that
  // rises once A, B and op have each been loaded and stays high until reset.
  modport slave (
    input  sw, btn_load_a, btn_load_b, btn_load_op, btn_page, alu_f, alu_nzcv,
    output a, b, alu_op, cf_in, vf_in, shift_cout, disp_data, page, nzcv_led,
           result_valid, dbg_loaded
  );

  modport master (
    output sw, btn_load_a, btn_load_b, btn_load_op, btn_page, alu_f, alu_nzcv,
    input  a, b, alu_op, cf_in, vf_in, shift_cout, disp_data, page, nzcv_led,
           result_valid, dbg_loaded
  );
endinterface

// File: rtl/alu_board_ctrl.sv
// ALU board front end: button sync/debounce, operand/op loading, 4-page display mux.
// Optional macro ALU_BOARD_AUTOPAGE_EN makes load pulses also select the page.
module alu_board_ctrl #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 4,
  parameter int DEB_CNT = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  alu_board_ctrl_if.slave bus
);
  localparam int NB     = 4;
  localparam int CW     = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;
  localparam int BTN_PG = 3;

  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} ld_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] deb_q, deb_d, deb_dly_q, pulse_q;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  ld_state_e ld_q [3];
  ld_state_e ld_d [3];

  logic [WIDTH-1:0] a_q, b_q, disp_q, disp_d, status;
  logic [OP_W-1:0]  op_q;
  logic             cf_q, vf_q, sc_q;
  logic [1:0]       page_q, page_d;
  logic [3:0]       nzcv_q;
  logic             valid_q;

  assign raw = {bus.btn_page, bus.btn_load_op, bus.btn_load_b, bus.btn_load_a};

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreeing sample throws the partial count away.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CNT - 1)) deb_d[i] = ~deb_q[i];
        else                              cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      pulse_q   <= deb_q & ~deb_dly_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Per-operand load tracking: EMPTY -> LOADED on its pulse, only reset returns.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ld_d[i] = ld_q[i];
      if (pulse_q[i]) ld_d[i] = LOADED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) ld_q[i] <= EMPTY;
    end else begin
      for (int i = 0; i < 3; i++) ld_q[i] <= ld_d[i];
    end
  end

  always_comb begin
    page_d = page_q;
`ifdef ALU_BOARD_AUTOPAGE_EN
    if      (pulse_q[BTN_OP]) page_d = 2'd2;
    else if (pulse_q[BTN_B])  page_d = 2'd1;
    else if (pulse_q[BTN_A])  page_d = 2'd0;
    else if (pulse_q[BTN_PG]) page_d = page_q + 2'd1;
`else
    if (pulse_q[BTN_PG]) page_d = page_q + 2'd1;
`endif
  end

  always_comb begin
    status            = '0;
    status[3:0]       = bus.alu_nzcv;
    status[6:4]       = {cf_q, vf_q, sc_q};
    status[6+OP_W:7]  = op_q;
    case (page_q)
      2'd0:    disp_d = a_q;
      2'd1:    disp_d = b_q;
      2'd2:    disp_d = bus.alu_f;
      default: disp_d = status;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      sc_q    <= 1'b0;
      page_q  <= 2'd0;
      disp_q  <= '0;
      nzcv_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      if (pulse_q[BTN_A]) a_q <= bus.sw;
      if (pulse_q[BTN_B]) b_q <= bus.sw;
      if (pulse_q[BTN_OP]) {op_q, cf_q, vf_q, sc_q} <= bus.sw[WIDTH-1 -: OP_W+3];
      page_q  <= page_d;
      disp_q  <= disp_d;
      nzcv_q  <= bus.alu_nzcv;
      valid_q <= (ld_d[0] == LOADED) && (ld_d[1] == LOADED) && (ld_d[2] == LOADED);
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.alu_op       = op_q;
  assign bus.cf_in        = cf_q;
  assign bus.vf_in        = vf_q;
  assign bus.shift_cout   = sc_q;
  assign bus.disp_data    = disp_q;
  assign bus.page         = page_q;
  assign bus.nzcv_led     = nzcv_q;
  assign bus.result_valid = valid_q;
  assign bus.dbg_loaded   = {ld_q[2] == LOADED, ld_q[1] == LOADED, ld_q[0] == LOADED};
endmodule

// File: tb/tb_alu_board_ctrl.sv
// Bench for alu_board_ctrl (DEB_CNT=4): directed scenarios with literal checks,
// then random button/switch traffic checked every cycle against a behavioural model.
module tb_alu_board_ctrl;
  localparam int WIDTH = 32;
  localparam int OP_W  = 4;
  localparam int DEB   = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_board_ctrl_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

  alu_board_ctrl #(.WIDTH(WIDTH), .OP_W(OP_W), .DEB_CNT(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [31:0] m_a, m_b, m_status, m_disp_new;
  logic [3:0]  m_op, m_nzcv, m_r, m_deb, m_p;
  logic        m_cf, m_vf, m_sc, m_valid, m_la, m_lb, m_lop;
  logic [1:0]  m_page;
  int          m_run [4];
  int          m_pend[4];
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_op = '0; m_cf = 0; m_vf = 0; m_sc = 0;
      m_page = 0; m_nzcv = 0; m_valid = 0; m_la = 0; m_lb = 0; m_lop = 0;
      m_deb = '0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_pend[i] = -1; end
      exp_q.delete();
    end else begin
      cyc++;
      m_status = {21'b0, m_op, m_cf, m_vf, m_sc, bus.alu_nzcv};
      case (m_page)
        2'd0: m_disp_new = m_a;
        2'd1: m_disp_new = m_b;
        2'd2: m_disp_new = bus.alu_f;
        default: m_disp_new = m_status;
      endcase
      exp_q.push_back(m_disp_new);
      for (int i = 0; i < 4; i++) m_p[i] = (m_pend[i] == cyc);
      if (m_p[0]) begin m_a = bus.sw; m_la = 1; end
      if (m_p[1]) begin m_b = bus.sw; m_lb = 1; end
      if (m_p[2]) begin {m_op, m_cf, m_vf, m_sc} = bus.sw[31:25]; m_lop = 1; end
`ifdef ALU_BOARD_AUTOPAGE_EN
      if (m_p[2])      m_page = 2;
      else if (m_p[1]) m_page = 1;
      else if (m_p[0]) m_page = 0;
      else if (m_p[3]) m_page = 2'((m_page + 1) % 4);
`else
      if (m_p[3]) m_page = 2'((m_page + 1) % 4);
`endif
      m_valid = m_la && m_lb && m_lop;
      m_nzcv  = bus.alu_nzcv;
      // A level is accepted after DEB raw samples in a row that disagree with it;
      // its effect lands 4 edges after the last of those samples.
      m_r = {bus.btn_page, bus.btn_load_op, bus.btn_load_b, bus.btn_load_a};
      for (int i = 0; i < 4; i++) begin
        if (m_r[i] != m_deb[i]) m_run[i]++;
        else                    m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_deb[i] = m_r[i];
          m_run[i] = 0;
          if (m_r[i]) m_pend[i] = cyc + 4;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      check("a",        bus.a,                  m_a);
      check("b",        bus.b,                  m_b);
      check("alu_op",   32'(bus.alu_op),        32'(m_op));
      check("cf_vf_sc", 32'({bus.cf_in, bus.vf_in, bus.shift_cout}), 32'({m_cf, m_vf, m_sc}));
      check("page",     32'(bus.page),          32'(m_page));
      check("nzcv_led", 32'(bus.nzcv_led),      32'(m_nzcv));
      check("valid",    32'(bus.result_valid),  32'(m_valid));
      check("loaded",   32'(bus.dbg_loaded),    32'({m_lop, m_lb, m_la}));
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL disp: no expected value queued at %0t", $time);
      end else begin
        check("disp", bus.disp_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: bus.btn_load_a  = v;
      1: bus.btn_load_b  = v;
      2: bus.btn_load_op = v;
      default: bus.btn_page = v;
    endcase
  endtask

  task automatic press(input int idx, input logic [31:0] sw_v);
    bus.sw = sw_v;
    set_btn(idx, 1'b1);
    tick(6);
    set_btn(idx, 1'b0);
    tick(10);
  endtask

  logic [3:0] lvl;

  initial begin
    rst_n = 1'b0;
    bus.sw = '0; bus.alu_f = '0; bus.alu_nzcv = '0;
    bus.btn_load_a = 0; bus.btn_load_b = 0; bus.btn_load_op = 0; bus.btn_page = 0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("idle_a",     bus.a,                 32'h0);
    check("idle_disp",  bus.disp_data,         32'h0);
    check("idle_page",  32'(bus.page),         32'h0);
    check("idle_valid", 32'(bus.result_valid), 32'h0);

    // Load A: pulse after edge 6, register after edge 7, display after edge 8.
    bus.sw = 32'h1234_5678;
    bus.btn_load_a = 1;
    tick(7);
    check("a_before_pulse", bus.a, 32'h0);
    tick(1);
    check("a_loaded", bus.a, 32'h1234_5678);
    check("model_a",  m_a,   32'h1234_5678);
    tick(1);
    check("disp_a", bus.disp_data, 32'h1234_5678);
    tick(1);
    bus.btn_load_a = 0;
    tick(10);

    // Short glitches on the page button are ignored.
    bus.btn_page = 1; tick(3); bus.btn_page = 0; tick(1);
    bus.btn_page = 1; tick(3); bus.btn_page = 0; tick(10);
    check("glitch_page", 32'(bus.page), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      press(3, bus.sw);
      check("page_step", 32'(bus.page), 32'(k % 4));
    end

    // Operands and op; result_valid the cycle after the op pulse.
    bus.alu_f = 32'd8;
    press(0, 32'd5);
    press(1, 32'd3);
    bus.sw = {7'b0010_100, 25'h0};
    bus.btn_load_op = 1;
    tick(8);
    check("valid_after_op", 32'(bus.result_valid), 32'h1);
    check("op_loaded",      32'(bus.alu_op),       32'h2);
    check("cf_loaded",      32'(bus.cf_in),        32'h1);
`ifdef ALU_BOARD_AUTOPAGE_EN
    check("autopage_op", 32'(bus.page), 32'h2);
    tick(1);
    check("disp_f", bus.disp_data, 32'd8);
`else
    check("page_kept", 32'(bus.page), 32'h0);
    tick(1);
    check("disp_a5", bus.disp_data, 32'd5);
`endif
    bus.btn_load_op = 0;
    tick(10);

    // B and page together: autopage forces 1 (from 2), else 0 increments to 1.
    bus.sw = 32'hCAFE_0001;
    bus.btn_load_b = 1; bus.btn_page = 1;
    tick(6);
    bus.btn_load_b = 0; bus.btn_page = 0;
    tick(10);
    check("simul_page", 32'(bus.page), 32'h1);
    check("simul_b",    bus.b,         32'hCAFE_0001);

    // Reset during an op debounce discards the press; a new full window follows.
    bus.sw = 32'hA000_0000;
    bus.btn_load_op = 1;
    tick(3);
    rst_n = 0;
    tick(2);
    rst_n = 1;
    tick(7);
    check("rst_op_none",  32'(bus.alu_op),       32'h0);
    check("rst_valid",    32'(bus.result_valid), 32'h0);
    check("rst_b",        bus.b,                 32'h0);
    tick(1);
    check("rst_op_late",  32'(bus.alu_op),       32'hA);
    check("rst_valid2",   32'(bus.result_valid), 32'h0);
    bus.btn_load_op = 0;
    tick(10);

    // Random traffic: buttons flip with random run lengths, data changes every cycle.
    lvl = '0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
      {bus.btn_page, bus.btn_load_op, bus.btn_load_b, bus.btn_load_a} = lvl;
      bus.sw       = $urandom;
      bus.alu_f    = $urandom;
      bus.alu_nzcv = 4'($urandom_range(0, 15));
      if (n == 400) begin
        rst_n = 0;
        tick(2);
        rst_n = 1;
      end
      tick(1);
    end
    {bus.btn_page, bus.btn_load_op, bus.btn_load_b, bus.btn_load_a} = 4'b0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_board_ctrl.md
Name: alu_board_ctrl

Overview:
- Front-end controller for the ALU board build.
- Synchronises and debounces four raw push-buttons, then loads operand A, operand B and the op/flag word from the switch bank into registers that drive the ALU.
- Sequences a 4-page display mux (A, B, F, status) into the 7-segment driver.
- Generalised in operand width and debounce depth; adds debouncing, reset, load tracking and optional auto-paging.

Parameters:
- WIDTH, 32, operand/result/display width in bits.
- OP_W, 4, ALU opcode width.
- DEB_CNT, 1000000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz). Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  WIDTH  switch bank, raw
- btn_load_a  in  1  raw button: load A
- btn_load_b  in  1  raw button: load B
- btn_load_op  in  1  raw button: load op/flags
- btn_page  in  1  raw button: next display page
- alu_f  in  WIDTH  ALU result
- alu_nzcv  in  4  ALU flags {N,Z,C,V}
- a  out  WIDTH  operand A register
- b  out  WIDTH  operand B register
- alu_op  out  OP_W  opcode register
- cf_in, vf_in, shift_cout  out  1 each  carry/overflow/shift-carry inputs to ALU
- disp_data  out  WIDTH  registered value for display driver
- page  out  2  current display page
- nzcv_led  out  4  registered copy of alu_nzcv
- result_valid  out  1  A, B and op all loaded since reset

Behaviour:
- Reset (async assert, sync release): all outputs 0, page=0, debounce counters 0, debounced levels 0, loaded mask 0.
- Per button: 2-flop synchroniser, then a debounce counter.
  - Counter increments while the synchronised level differs from the debounced level; clears when they match.
  - On reaching DEB_CNT the debounced level toggles and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle pulse. Falling edges give no pulse.
- Latency: raw level high and stable, first sampled at edge 0 -> pulse high for the cycle after edge DEB_CNT+2. Exactly one pulse per press.
- Glitches shorter than DEB_CNT cycles: ignored, counter restarts.
- Load A pulse: a <= sw. Load B pulse: b <= sw.
- Load op pulse: {alu_op, cf_in, vf_in, shift_cout} <= sw[WIDTH-1 -: OP_W+3]. Registers update on the pulse edge.
- Loaded mask {op,b,a}: state per bit is EMPTY -> LOADED on the matching pulse; no return except reset. result_valid = &mask, registered, asserted the cycle after the last pulse.
- Page counter: page pulse -> page <= page+1, mod 4. 3 wraps to 0.
- Page contents:
  - 0 = a
  - 1 = b
  - 2 = alu_f
  - 3 = status, zero-extended: bits[3:0]=alu_nzcv, [6:4]={cf_in,vf_in,shift_cout}, [6+OP_W:7]=alu_op.
- disp_data and nzcv_led are registered every cycle from the current page and live inputs (1-cycle latency, tracks F continuously).
- Simultaneous pulses: all loads apply in the same cycle. Page priority is given under Optional Feature.
- Reset mid-debounce: press is discarded; no pulse after release of reset until a full new DEB_CNT window.

Optional Feature:
- Macro: ALU_BOARD_AUTOPAGE_EN.
- Defined: each load pulse also forces page (A->0, B->1, op->2). Priority op > B > A > page button; page button ignored in any cycle with a load pulse.
- Undefined: page changes only via btn_page; loads never alter page.

Test Plan:
All scenarios use DEB_CNT=4, WIDTH=32.
- Reset then idle 20 cycles -> all outputs 0, page=0, result_valid=0.
- sw=32'h1234_5678, hold btn_load_a high 10 cycles -> single pulse at cycle 6, a=32'h1234_5678 at cycle 7. disp_data=32'h1234_5678 one cycle later (page 0).
- btn_page toggled high 3 cycles, low, high 3 cycles -> no pulse, page stays 0. Then 4 clean presses -> page goes 1,2,3,0.
- Load A=5, B=3, sw[31:25]=7'b0010_100 via op button, alu_f driven 8, nzcv=4'b0000 -> result_valid=1 the cycle after the op pulse. With AUTOPAGE_EN: page=2, disp_data=8. Without: page unchanged.
- btn_load_b and btn_page pressed in the same cycle with AUTOPAGE_EN -> page=1, no increment. Without the macro -> page increments, b loaded.
- Assert rst_n low during cycle 3 of a btn_load_op debounce, release, keep button high -> no pulse until 6 cycles after release; mask cleared, result_valid=0.
